// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the write-back data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } dcache_state_e;

    typedef struct packed {
        logic valid;
        logic dirty;
    } line_meta_t;

    function automatic int unsigned off_bits(input int unsigned line_w,
                                             input int unsigned data_w);
        return $clog2(line_w / data_w);
    endfunction

    function automatic int unsigned idx_bits(input int unsigned num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned addr_w,
                                             input int unsigned line_w,
                                             input int unsigned data_w,
                                             input int unsigned num_sets);
        return addr_w - off_bits(line_w, data_w) - idx_bits(num_sets);
    endfunction

endpackage

// File: rtl/dcache_wb_if.sv
// Core-side and memory-side signals of the data cache; the cache is the slave.
interface dcache_wb_if #(
    parameter int unsigned ADDRESS_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned CACHE_LINE_WIDTH = 128
);
    logic                          req_valid;
    logic                          store;
    logic [ADDRESS_WIDTH-1:0]      addr;
    logic [DATA_WIDTH-1:0]         data_in;
    logic [DATA_WIDTH/8-1:0]       byte_en;
    logic                          hit;
    logic [DATA_WIDTH-1:0]         data_out;
    logic                          stall;
    logic                          mem_req;
    logic                          mem_we;
    logic [ADDRESS_WIDTH-1:0]      mem_addr;
    logic [CACHE_LINE_WIDTH-1:0]   mem_wdata;
    logic [CACHE_LINE_WIDTH-1:0]   mem_rdata;
    logic                          mem_valid;

    modport master (
        output req_valid, store, addr, data_in, byte_en, mem_rdata, mem_valid,
        input  hit, data_out, stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, store, addr, data_in, byte_en, mem_rdata, mem_valid,
        output hit, data_out, stall, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_way.sv
// One cache way: per-set valid/dirty/tag/data storage with tag compare,
// byte-enabled word write and full-line fill.
module dcache_way import dcache_pkg::*; #(
    parameter int unsigned TAG_WIDTH        = 28,
    parameter int unsigned IDX_WIDTH        = 2,
    parameter int unsigned OFF_WIDTH        = 2,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned CACHE_LINE_WIDTH = 128,
    parameter int unsigned NUM_SETS         = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [IDX_WIDTH-1:0]        i_idx,
    input  logic [TAG_WIDTH-1:0]        i_tag,
    output logic                        o_hit,
    output line_meta_t                  o_meta,
    output logic [TAG_WIDTH-1:0]        o_tag,
    output logic [CACHE_LINE_WIDTH-1:0] o_line,
    input  logic                        i_wr_en,
    input  logic [OFF_WIDTH-1:0]        i_wr_off,
    input  logic [DATA_WIDTH-1:0]       i_wr_data,
    input  logic [DATA_WIDTH/8-1:0]     i_wr_be,
    input  logic                        i_fill_en,
    input  logic                        i_clean_en,
    input  logic [IDX_WIDTH-1:0]        i_upd_idx,
    input  logic [TAG_WIDTH-1:0]        i_fill_tag,
    input  logic [CACHE_LINE_WIDTH-1:0] i_fill_line
);
    localparam int unsigned WORDS = CACHE_LINE_WIDTH / DATA_WIDTH;

    logic [NUM_SETS-1:0]         r_valid;
    logic [NUM_SETS-1:0]         r_dirty;
    logic [TAG_WIDTH-1:0]        r_tag  [NUM_SETS];
    logic [CACHE_LINE_WIDTH-1:0] r_data [NUM_SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (i_fill_en) begin
                r_valid[i_upd_idx] <= 1'b1;
                r_dirty[i_upd_idx] <= 1'b0;
            end else if (i_clean_en) begin
                r_dirty[i_upd_idx] <= 1'b0;
            end
            if (i_wr_en) begin
                r_dirty[i_idx] <= 1'b1;
            end
        end
    end

    // Tag and data are plain storage; validity alone guards them after reset.
    always_ff @(posedge clk) begin
        if (i_fill_en) begin
            r_tag[i_upd_idx]  <= i_fill_tag;
            r_data[i_upd_idx] <= i_fill_line;
        end else if (i_wr_en) begin
            for (int w = 0; w < int'(WORDS); w++) begin
                for (int b = 0; b < int'(DATA_WIDTH / 8); b++) begin
                    if (i_wr_off == OFF_WIDTH'(w) && i_wr_be[b]) begin
                        r_data[i_idx][w*DATA_WIDTH + b*8 +: 8] <= i_wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    assign o_hit        = r_valid[i_idx] && (r_tag[i_idx] == i_tag);
    assign o_meta.valid = r_valid[i_idx];
    assign o_meta.dirty = r_dirty[i_idx];
    assign o_tag        = r_tag[i_idx];
    assign o_line       = r_data[i_idx];

endmodule

// File: rtl/dcache_wb.sv
// Set-associative write-back, write-allocate data cache: combinational hit path,
// victim writeback / line fill state machine with round-robin replacement.
module dcache_wb import dcache_pkg::*; #(
    parameter int unsigned ADDRESS_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned CACHE_LINE_WIDTH = 128,
    parameter int unsigned NUM_SETS         = 4,
    parameter int unsigned NUM_WAYS         = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    dcache_wb_if.slave bus
);
    localparam int unsigned WORDS = CACHE_LINE_WIDTH / DATA_WIDTH;
    localparam int unsigned OFF   = off_bits(CACHE_LINE_WIDTH, DATA_WIDTH);
    localparam int unsigned IDX   = idx_bits(NUM_SETS);
    localparam int unsigned TAGW  = tag_bits(ADDRESS_WIDTH, CACHE_LINE_WIDTH, DATA_WIDTH, NUM_SETS);
    localparam int unsigned OFFW  = (OFF > 0) ? OFF : 1;
    localparam int unsigned IDXW  = (IDX > 0) ? IDX : 1;
    localparam int unsigned WAYW  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    logic [OFFW-1:0] w_off;
    logic [IDXW-1:0] w_idx;
    logic [TAGW-1:0] w_tag;

    assign w_off = OFFW'(bus.addr) & OFFW'(WORDS - 1);
    assign w_idx = IDXW'(bus.addr >> OFF) & IDXW'(NUM_SETS - 1);
    assign w_tag = TAGW'(bus.addr >> (OFF + IDX));

    function automatic logic [ADDRESS_WIDTH-1:0] line_addr(input logic [TAGW-1:0] tag,
                                                           input logic [IDXW-1:0] idx);
        return (ADDRESS_WIDTH'(tag) << (OFF + IDX)) | (ADDRESS_WIDTH'(idx) << OFF);
    endfunction

    dcache_state_e                r_state;
    logic [WAYW-1:0]              r_victim;
    logic                         r_by_ptr;
    logic [IDXW-1:0]              r_idx;
    logic [TAGW-1:0]              r_tag;
    logic [WAYW-1:0]              r_ptr [NUM_SETS];
    logic                         r_mem_req;
    logic                         r_mem_we;
    logic [ADDRESS_WIDTH-1:0]     r_mem_addr;
    logic [CACHE_LINE_WIDTH-1:0]  r_mem_wdata;

    logic [NUM_WAYS-1:0]          w_way_hit;
    logic [NUM_WAYS-1:0]          w_way_valid;
    logic [NUM_WAYS-1:0]          w_way_dirty;
    line_meta_t                   w_meta     [NUM_WAYS];
    logic [TAGW-1:0]              w_way_tag  [NUM_WAYS];
    logic [CACHE_LINE_WIDTH-1:0]  w_way_line [NUM_WAYS];
    logic                         w_hit;
    logic [DATA_WIDTH-1:0]        w_rdata;
    logic [WAYW-1:0]              w_victim;
    logic                         w_by_ptr;

    assign w_hit = bus.req_valid && (r_state == IDLE) && (|w_way_hit);

    for (genvar g = 0; g < int'(NUM_WAYS); g++) begin : g_way
        dcache_way #(
            .TAG_WIDTH        (TAGW),
            .IDX_WIDTH        (IDXW),
            .OFF_WIDTH        (OFFW),
            .DATA_WIDTH       (DATA_WIDTH),
            .CACHE_LINE_WIDTH (CACHE_LINE_WIDTH),
            .NUM_SETS         (NUM_SETS)
        ) u_way (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_idx       (w_idx),
            .i_tag       (w_tag),
            .o_hit       (w_way_hit[g]),
            .o_meta      (w_meta[g]),
            .o_tag       (w_way_tag[g]),
            .o_line      (w_way_line[g]),
            .i_wr_en     (w_hit && bus.store && w_way_hit[g]),
            .i_wr_off    (w_off),
            .i_wr_data   (bus.data_in),
            .i_wr_be     (bus.byte_en),
            .i_fill_en   ((r_state == FILL) && bus.mem_valid && (r_victim == WAYW'(g))),
            .i_clean_en  ((r_state == WRITEBACK) && bus.mem_valid && (r_victim == WAYW'(g))),
            .i_upd_idx   (r_idx),
            .i_fill_tag  (r_tag),
            .i_fill_line (bus.mem_rdata)
        );
        assign w_way_valid[g] = w_meta[g].valid;
        assign w_way_dirty[g] = w_meta[g].dirty;
    end

    always_comb begin
        w_rdata = '0;
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            if (w_way_hit[w]) begin
                w_rdata = w_rdata | w_way_line[w][w_off*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Lowest-index invalid way wins; otherwise fall back to the set's pointer.
    always_comb begin
        w_victim = r_ptr[w_idx];
        w_by_ptr = 1'b1;
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (!w_way_valid[w]) begin
                w_victim = WAYW'(w);
                w_by_ptr = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_victim    <= '0;
            r_by_ptr    <= 1'b0;
            r_idx       <= '0;
            r_tag       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            for (int s = 0; s < int'(NUM_SETS); s++) begin
                r_ptr[s] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid && !(|w_way_hit)) begin
                        r_victim  <= w_victim;
                        r_by_ptr  <= w_by_ptr;
                        r_idx     <= w_idx;
                        r_tag     <= w_tag;
                        r_mem_req <= 1'b1;
                        if (w_way_valid[w_victim] && w_way_dirty[w_victim]) begin
                            r_state     <= WRITEBACK;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= line_addr(w_way_tag[w_victim], w_idx);
                            r_mem_wdata <= w_way_line[w_victim];
                        end else begin
                            r_state    <= FILL;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= line_addr(w_tag, w_idx);
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_valid) begin
                        r_state    <= FILL;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= line_addr(r_tag, r_idx);
                    end
                end
                FILL: begin
                    if (bus.mem_valid) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                        if (r_by_ptr) begin
                            r_ptr[r_idx] <= WAYW'((32'(r_ptr[r_idx]) + 32'd1) % 32'(NUM_WAYS));
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.hit       = w_hit;
    assign bus.data_out  = w_hit ? w_rdata : '0;
    assign bus.stall     = bus.req_valid && !w_hit;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule
